// File: rtl/eth_mem_apb_arbiter_pkg.sv
// Shared types and defaults for the Ethernet memory-port APB arbiter.
package eth_mem_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_e;

   typedef enum logic {
      OWN_TX = 1'b0,
      OWN_RX = 1'b1
   } owner_e;

endpackage

// File: rtl/eth_mem_apb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: index 0 is TX, index 1 is RX; reset favours TX.
module eth_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic prio_rx_r;

   // One-hot grant; the pointer only matters when both are asking
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = prio_rx_r ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

   // Pointer moves to the requester that was not just granted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio_rx_r <= 1'b0;
      end else if (advance && (gnt != 2'b00)) begin
         prio_rx_r <= gnt[0];
      end else begin
         prio_rx_r <= prio_rx_r;
      end
   end

endmodule

// File: rtl/eth_mem_apb_arbiter.sv
// Shares one APB memory master between the TX fetch and RX store requesters,
// with round-robin arbitration and a PREADY timeout per transfer.
module eth_mem_apb_arbiter
   import eth_mem_pkg::*;
#(
   parameter int unsigned ADDR_W         = ADDR_W_DEF,
   parameter int unsigned DATA_W         = DATA_W_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned CNT_W          = 9
) (
   input  logic              pclk_i,
   input  logic              prst_i,
   input  logic              tx_req_i,
   input  logic              tx_write_i,
   input  logic [ADDR_W-1:0] tx_addr_i,
   input  logic [DATA_W-1:0] tx_wdata_i,
   output logic              tx_done_o,
   output logic              tx_err_o,
   output logic [DATA_W-1:0] tx_rdata_o,
   input  logic              rx_req_i,
   input  logic              rx_write_i,
   input  logic [ADDR_W-1:0] rx_addr_i,
   input  logic [DATA_W-1:0] rx_wdata_i,
   output logic              rx_done_o,
   output logic              rx_err_o,
   output logic [DATA_W-1:0] rx_rdata_o,
   output logic              m_psel_o,
   output logic              m_penable_o,
   output logic              m_pwrite_o,
   output logic [ADDR_W-1:0] m_paddr_o,
   output logic [DATA_W-1:0] m_pwdata_o,
   input  logic              m_pready_i,
   input  logic [DATA_W-1:0] m_prdata_i
);

   state_e            state_r;
   owner_e            owner_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              m_psel_r, m_penable_r, m_pwrite_r;
   logic [ADDR_W-1:0] m_paddr_r;
   logic [DATA_W-1:0] m_pwdata_r;
   logic              tx_done_r, tx_err_r, rx_done_r, rx_err_r;
   logic [DATA_W-1:0] tx_rdata_r, rx_rdata_r;
   logic [1:0]        elig_s;
   logic [1:0]        gnt_s;
   logic              grant_s;
   logic              timeout_hit_s;
   logic [DATA_W-1:0] rd_capture_s;

   // A requester seeing its done pulse still has a stale req up; mask it
   always_comb begin
      elig_s        = {rx_req_i & ~rx_done_r, tx_req_i & ~tx_done_r};
      grant_s       = (state_r == IDLE) && (gnt_s != 2'b00);
      timeout_hit_s = (TIMEOUT_CYCLES != 32'd0) &&
                      ((cnt_r + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));
      if (m_pwrite_r) begin
         rd_capture_s = {DATA_W{1'b0}};
      end else begin
         rd_capture_s = m_prdata_i;
      end
   end

   eth_rr_arb2 u_arb (
      .clk     (pclk_i),
      .rst     (prst_i),
      .req     (elig_s),
      .advance (grant_s),
      .gnt     (gnt_s)
   );

   // Transfer sequencer; completion outputs are single-cycle and default to 0
   always_ff @(posedge pclk_i or posedge prst_i) begin
      if (prst_i) begin
         state_r     <= IDLE;
         owner_r     <= OWN_TX;
         cnt_r       <= {CNT_W{1'b0}};
         m_psel_r    <= 1'b0;
         m_penable_r <= 1'b0;
         m_pwrite_r  <= 1'b0;
         m_paddr_r   <= {ADDR_W{1'b0}};
         m_pwdata_r  <= {DATA_W{1'b0}};
         tx_done_r   <= 1'b0;
         tx_err_r    <= 1'b0;
         tx_rdata_r  <= {DATA_W{1'b0}};
         rx_done_r   <= 1'b0;
         rx_err_r    <= 1'b0;
         rx_rdata_r  <= {DATA_W{1'b0}};
      end else begin
         tx_done_r  <= 1'b0;
         tx_err_r   <= 1'b0;
         tx_rdata_r <= {DATA_W{1'b0}};
         rx_done_r  <= 1'b0;
         rx_err_r   <= 1'b0;
         rx_rdata_r <= {DATA_W{1'b0}};
         case (state_r)
            IDLE: begin
               m_penable_r <= 1'b0;
               if (grant_s) begin
                  state_r  <= SETUP;
                  m_psel_r <= 1'b1;
                  cnt_r    <= {CNT_W{1'b0}};
                  if (gnt_s[1]) begin
                     owner_r    <= OWN_RX;
                     m_pwrite_r <= rx_write_i;
                     m_paddr_r  <= rx_addr_i;
                     m_pwdata_r <= rx_wdata_i;
                  end else begin
                     owner_r    <= OWN_TX;
                     m_pwrite_r <= tx_write_i;
                     m_paddr_r  <= tx_addr_i;
                     m_pwdata_r <= tx_wdata_i;
                  end
               end else begin
                  m_psel_r <= 1'b0;
               end
            end
            SETUP: begin
               state_r     <= ACCESS;
               m_psel_r    <= 1'b1;
               m_penable_r <= 1'b1;
            end
            ACCESS: begin
               if (m_pready_i || timeout_hit_s) begin
                  state_r     <= IDLE;
                  m_psel_r    <= 1'b0;
                  m_penable_r <= 1'b0;
                  if (owner_r == OWN_RX) begin
                     rx_done_r  <= 1'b1;
                     rx_err_r   <= ~m_pready_i;
                     rx_rdata_r <= m_pready_i ? rd_capture_s : {DATA_W{1'b0}};
                  end else begin
                     tx_done_r  <= 1'b1;
                     tx_err_r   <= ~m_pready_i;
                     tx_rdata_r <= m_pready_i ? rd_capture_s : {DATA_W{1'b0}};
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            default: begin
               state_r     <= IDLE;
               m_psel_r    <= 1'b0;
               m_penable_r <= 1'b0;
            end
         endcase
      end
   end

   assign m_psel_o    = m_psel_r;
   assign m_penable_o = m_penable_r;
   assign m_pwrite_o  = m_pwrite_r;
   assign m_paddr_o   = m_paddr_r;
   assign m_pwdata_o  = m_pwdata_r;
   assign tx_done_o   = tx_done_r;
   assign tx_err_o    = tx_err_r;
   assign tx_rdata_o  = tx_rdata_r;
   assign rx_done_o   = rx_done_r;
   assign rx_err_o    = rx_err_r;
   assign rx_rdata_o  = rx_rdata_r;

endmodule

// File: tb/tb_eth_mem_apb_arbiter.sv
// Bench for eth_mem_apb_arbiter: behavioural APB memory plus per-requester
// expected-memory shadow; timeout shortened to 4 cycles.
module tb_eth_mem_apb_arbiter;

   logic        pclk = 1'b0;
   logic        prst = 1'b1;
   logic        tx_req = 1'b0, tx_write = 1'b0;
   logic [31:0] tx_addr = 32'd0, tx_wdata = 32'd0;
   logic        tx_done, tx_err;
   logic [31:0] tx_rdata;
   logic        rx_req = 1'b0, rx_write = 1'b0;
   logic [31:0] rx_addr = 32'd0, rx_wdata = 32'd0;
   logic        rx_done, rx_err;
   logic [31:0] rx_rdata;
   logic        m_psel, m_penable, m_pwrite;
   logic [31:0] m_paddr, m_pwdata;
   logic        m_pready = 1'b0;
   logic [31:0] m_prdata = 32'd0;

   int vec_cnt = 0;
   int err_cnt = 0;

   // memory model state
   logic [31:0] mem     [logic [31:0]];
   logic [31:0] exp_mem [logic [31:0]];
   int  acc_n = 0;
   int  waits_cur = 0;
   int  fixed_waits = 0;
   bit  rand_waits = 1'b0;
   bit  hang = 1'b0;
   bit  done_order [$];
   bit  model_last_rx = 1'b1;

   eth_mem_apb_arbiter #(
      .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4), .CNT_W(9)
   ) dut (
      .pclk_i(pclk), .prst_i(prst),
      .tx_req_i(tx_req), .tx_write_i(tx_write), .tx_addr_i(tx_addr), .tx_wdata_i(tx_wdata),
      .tx_done_o(tx_done), .tx_err_o(tx_err), .tx_rdata_o(tx_rdata),
      .rx_req_i(rx_req), .rx_write_i(rx_write), .rx_addr_i(rx_addr), .rx_wdata_i(rx_wdata),
      .rx_done_o(rx_done), .rx_err_o(rx_err), .rx_rdata_o(rx_rdata),
      .m_psel_o(m_psel), .m_penable_o(m_penable), .m_pwrite_o(m_pwrite),
      .m_paddr_o(m_paddr), .m_pwdata_o(m_pwdata),
      .m_pready_i(m_pready), .m_prdata_i(m_prdata)
   );

   always #5 pclk = ~pclk;

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : dflt(a);
   endfunction

   function automatic logic [31:0] exp_rd(input logic [31:0] a);
      return exp_mem.exists(a) ? exp_mem[a] : dflt(a);
   endfunction

   // APB memory: answers after waits_cur wait states, never when hang is set
   always @(negedge pclk) begin
      if (m_psel && !m_penable) begin
         acc_n     = 0;
         waits_cur = rand_waits ? int'($urandom_range(0, 3)) : fixed_waits;
      end
      if (m_psel && m_penable) begin
         acc_n = acc_n + 1;
         if (!hang && acc_n > waits_cur) begin
            m_pready = 1'b1;
            if (m_pwrite) begin
               mem[m_paddr] = m_pwdata;
               m_prdata = $urandom;
            end else begin
               m_prdata = mem_rd(m_paddr);
            end
         end else begin
            m_pready = 1'b0;
            m_prdata = $urandom;
         end
      end else begin
         m_pready = 1'($urandom_range(0, 1));
         m_prdata = $urandom;
      end
   end

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic drive(input bit is_rx, input logic rq, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
      if (is_rx) begin
         rx_req = rq; rx_write = wr; rx_addr = a; rx_wdata = d;
      end else begin
         tx_req = rq; tx_write = wr; tx_addr = a; tx_wdata = d;
      end
   endtask

   // one requester issuing n random transfers in a small address window
   task automatic run_req(input bit is_rx, input int n, input logic [31:0] base);
      logic        wr;
      logic [31:0] a, d, exp_data, got_data;
      logic        got_err;
      bit          seen;
      for (int i = 0; i < n; i++) begin
         wr = 1'($urandom_range(0, 1));
         a  = base + 32'($urandom_range(0, 3)) * 32'd4;
         d  = $urandom;
         if (wr) begin
            exp_mem[a] = d;
            exp_data   = 32'd0;
         end else begin
            exp_data = exp_rd(a);
         end
         drive(is_rx, 1'b1, wr, a, d);
         seen = 1'b0;
         for (int c = 0; c < 100 && !seen; c++) begin
            tick();
            if (is_rx ? rx_done : tx_done) begin
               seen     = 1'b1;
               got_data = is_rx ? rx_rdata : tx_rdata;
               got_err  = is_rx ? rx_err : tx_err;
               done_order.push_back(is_rx);
               model_last_rx = is_rx;
               vec_cnt++;
               if (got_data !== exp_data || got_err !== 1'b0) begin
                  err_cnt++;
                  $display("FAIL %s_xfer%0d addr=%h wr=%0d: got rdata=%h err=%b, want rdata=%h err=0",
                           is_rx ? "rx" : "tx", i, a, wr, got_data, got_err, exp_data);
               end
            end
         end
         if (!seen) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL %s_done_timeout xfer%0d: got no done, want done", is_rx ? "rx" : "tx", i);
         end
      end
      drive(is_rx, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge pclk);
      #1;
      prst = 1'b0;
      tick();
      vec_cnt++;
      if ({m_psel, m_penable, m_pwrite, tx_done, tx_err, rx_done, rx_err} !== 7'd0 ||
          m_paddr !== 32'd0 || m_pwdata !== 32'd0 || tx_rdata !== 32'd0 || rx_rdata !== 32'd0) begin
         err_cnt++;
         $display("FAIL reset_outputs: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h, want all 0",
                  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata);
      end
   endtask

   task automatic test_tx_write();
      fixed_waits = 0; rand_waits = 1'b0; hang = 1'b0;
      exp_mem[32'h40] = 32'hDEAD_BEEF;
      drive(1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
      tick();
      vec_cnt++;
      if (m_psel !== 1'b1 || m_penable !== 1'b0 || m_pwrite !== 1'b1 ||
          m_paddr !== 32'h40 || m_pwdata !== 32'hDEAD_BEEF) begin
         err_cnt++;
         $display("FAIL txw_setup: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h, want 1 0 1 00000040 deadbeef",
                  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata);
      end
      tick();
      vec_cnt++;
      if (m_psel !== 1'b1 || m_penable !== 1'b1 || m_pwrite !== 1'b1 || tx_done !== 1'b0) begin
         err_cnt++;
         $display("FAIL txw_access: got psel=%b pen=%b pwr=%b done=%b, want 1 1 1 0",
                  m_psel, m_penable, m_pwrite, tx_done);
      end
      tick();
      vec_cnt++;
      if (tx_done !== 1'b1 || tx_err !== 1'b0 || tx_rdata !== 32'd0 ||
          rx_done !== 1'b0 || rx_err !== 1'b0 || rx_rdata !== 32'd0 || m_psel !== 1'b0) begin
         err_cnt++;
         $display("FAIL txw_done: got txd=%b txe=%b txr=%h rxd=%b rxe=%b rxr=%h psel=%b, want 1 0 0 0 0 0 0",
                  tx_done, tx_err, tx_rdata, rx_done, rx_err, rx_rdata, m_psel);
      end
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      model_last_rx = 1'b0;
      tick();
      vec_cnt++;
      if (tx_done !== 1'b0 || mem_rd(32'h40) !== 32'hDEAD_BEEF) begin
         err_cnt++;
         $display("FAIL txw_after: got done=%b mem=%h, want done=0 mem=deadbeef", tx_done, mem_rd(32'h40));
      end
   endtask

   task automatic test_rx_read_wait();
      fixed_waits = 3;
      mem[32'h100]     = 32'h1234_5678;
      exp_mem[32'h100] = 32'h1234_5678;
      drive(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
      tick();
      for (int c = 0; c < 4; c++) begin
         tick();
         vec_cnt++;
         if (m_psel !== 1'b1 || m_penable !== 1'b1 || m_pwrite !== 1'b0 ||
             m_paddr !== 32'h100 || rx_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL rxr_access%0d: got psel=%b pen=%b pwr=%b paddr=%h done=%b, want 1 1 0 00000100 0",
                     c, m_psel, m_penable, m_pwrite, m_paddr, rx_done);
         end
      end
      tick();
      vec_cnt++;
      if (rx_done !== 1'b1 || rx_err !== 1'b0 || rx_rdata !== 32'h1234_5678 || tx_done !== 1'b0) begin
         err_cnt++;
         $display("FAIL rxr_done: got done=%b err=%b rdata=%h txd=%b, want 1 0 12345678 0",
                  rx_done, rx_err, rx_rdata, tx_done);
      end
      drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      model_last_rx = 1'b1;
      tick();
   endtask

   task automatic test_round_robin();
      bit first_rx;
      rand_waits = 1'b1;
      first_rx   = ~model_last_rx;
      done_order.delete();
      fork
         run_req(1'b0, 3, 32'h0000_1000);
         run_req(1'b1, 3, 32'h0000_2000);
      join
      vec_cnt++;
      if (done_order.size() != 6) begin
         err_cnt++;
         $display("FAIL rr_count: got %0d dones, want 6", done_order.size());
      end else begin
         for (int k = 0; k < 6; k++) begin
            vec_cnt++;
            if (done_order[k] !== (first_rx ^ k[0])) begin
               err_cnt++;
               $display("FAIL rr_order%0d: got %s, want %s", k,
                        done_order[k] ? "rx" : "tx", (first_rx ^ k[0]) ? "rx" : "tx");
            end
         end
      end
      // more random traffic with both requesters
      fork
         run_req(1'b0, 8, 32'h0000_1000);
         run_req(1'b1, 8, 32'h0000_2000);
      join
      repeat (3) begin
         tick();
         vec_cnt++;
         if (tx_done !== 1'b0 || rx_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL rr_extra_done: got txd=%b rxd=%b, want 0 0", tx_done, rx_done);
         end
      end
   endtask

   task automatic test_timeout();
      int  acc;
      bit  seen;
      rand_waits = 1'b0; hang = 1'b1;
      acc = 0; seen = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 32'h0000_1008, 32'h0);
      for (int c = 0; c < 30 && !seen; c++) begin
         tick();
         if (m_psel && m_penable) acc++;
         if (tx_done) seen = 1'b1;
      end
      vec_cnt++;
      if (!seen || acc != 4 || tx_err !== 1'b1 || tx_rdata !== 32'd0) begin
         err_cnt++;
         $display("FAIL timeout: got seen=%0d access=%0d err=%b rdata=%h, want 1 4 1 00000000",
                  seen, acc, tx_err, tx_rdata);
      end
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      model_last_rx = 1'b0;
      hang = 1'b0; fixed_waits = 1;
      tick();
      vec_cnt++;
      if (m_psel !== 1'b0 || m_penable !== 1'b0) begin
         err_cnt++;
         $display("FAIL timeout_idle: got psel=%b pen=%b, want 0 0", m_psel, m_penable);
      end
      run_req(1'b1, 2, 32'h0000_2000);
   endtask

   task automatic test_reset_mid();
      bit in_access;
      hang = 1'b1; in_access = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 32'h0000_2004, 32'h0);
      for (int c = 0; c < 10 && !in_access; c++) begin
         tick();
         if (m_psel && m_penable) in_access = 1'b1;
      end
      vec_cnt++;
      if (!in_access) begin
         err_cnt++;
         $display("FAIL rstmid_access: got no ACCESS phase, want ACCESS");
      end
      prst = 1'b1;
      #1;
      vec_cnt++;
      if (m_psel !== 1'b0 || m_penable !== 1'b0) begin
         err_cnt++;
         $display("FAIL rstmid_async: got psel=%b pen=%b, want 0 0", m_psel, m_penable);
      end
      drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      hang = 1'b0; rand_waits = 1'b1;
      repeat (2) begin
         tick();
         vec_cnt++;
         if (tx_done !== 1'b0 || rx_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL rstmid_no_done: got txd=%b rxd=%b, want 0 0", tx_done, rx_done);
         end
      end
      prst = 1'b0;
      tick();
      done_order.delete();
      fork
         run_req(1'b1, 1, 32'h0000_2000);
         run_req(1'b0, 1, 32'h0000_1000);
      join
      vec_cnt++;
      if (done_order.size() != 2 || done_order[0] !== 1'b0) begin
         err_cnt++;
         $display("FAIL rstmid_favour_tx: got %0d dones first=%s, want 2 first=tx",
                  done_order.size(), (done_order.size() > 0 && done_order[0]) ? "rx" : "tx");
      end
   endtask

   initial begin
      test_reset();
      test_tx_write();
      test_rx_read_wait();
      test_round_robin();
      test_timeout();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/eth_mem_apb_arbiter.md
Name: eth_mem_apb_arbiter

Overview:
- Shares the Ethernet core's single APB memory master port (m_p* bus) between two internal requesters: TX (frame fetch) and RX (frame store).
- Arbitrates round-robin and runs the APB master SETUP/ACCESS sequence, including m_pready_i wait states.
- Guards each transfer with a PREADY timeout and returns completion, read data and error status to the owning requester.

Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, memory data width
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles before forced error termination; 0 disables the timeout
- CNT_W, 9, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
- pclk_i  in  1  clock
- prst_i  in  1  reset, asynchronous, active-high
- tx_req_i  in  1  TX transfer request; held high with stable command until tx_done_o
- tx_write_i  in  1  TX direction: 1 = write
- tx_addr_i  in  ADDR_W  TX address
- tx_wdata_i  in  DATA_W  TX write data
- tx_done_o  out  1  one-cycle completion pulse
- tx_err_o  out  1  valid with tx_done_o: timeout occurred
- tx_rdata_o  out  DATA_W  read data, valid with tx_done_o
- rx_req_i, rx_write_i, rx_addr_i, rx_wdata_i, rx_done_o, rx_err_o, rx_rdata_o: RX requester, same semantics as TX
- m_psel_o  out  1  APB select
- m_penable_o  out  1  APB enable
- m_pwrite_o  out  1  APB direction
- m_paddr_o  out  ADDR_W  APB address
- m_pwdata_o  out  DATA_W  APB write data
- m_pready_i  in  1  APB ready from memory
- m_prdata_i  in  DATA_W  APB read data from memory

Behaviour:
- Reset: one clock (pclk_i); reset prst_i is asynchronous and active-high.
  - All outputs go to 0 and the FSM goes to IDLE.
  - The round-robin pointer is set to favour TX.
  - Reset asserted mid-transfer drops the transfer with no done pulse.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - A requester is eligible when its req is high and its done_o is low in the current cycle. This masks the stale req in the cycle the requester sees done.
  - If no requester is eligible, stay in IDLE.
  - If exactly one is eligible, grant it.
  - If both are eligible, grant the one not granted last.
  - On a grant: register owner, write, addr and wdata; go to SETUP.
- SETUP: m_psel_o=1, m_penable_o=0, command from the registered copy; lasts exactly one cycle, then ACCESS.
- ACCESS: m_psel_o=1, m_penable_o=1, command held stable.
  - If m_pready_i=1 in a cycle: that is the last ACCESS cycle. Capture m_prdata_i if it is a read, otherwise capture 0. Go to IDLE.
  - If m_pready_i=0: increment the timeout counter.
  - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES: terminate with err=1 and rdata=0, then go to IDLE.
- Completion timing:
  - Owner done_o (registered) is high for exactly one cycle: the cycle after the final ACCESS cycle.
  - err_o and rdata_o are valid in that same cycle.
  - The non-owner's outputs stay 0.
- Idle bus values:
  - In IDLE, m_psel_o and m_penable_o are 0.
  - m_paddr_o, m_pwdata_o and m_pwrite_o hold their last values (0 after reset).
- Latency:
  - Zero-wait transfer: req sampled at edge 0, SETUP at cycle 1, ACCESS at cycle 2, done at cycle 3.
  - Minimum spacing between transfers: 3 cycles.
- Round-robin pointer:
  - Updates on grant only.
  - A lone requester may be granted repeatedly.
- The timeout counter clears on entry to SETUP.
- Address: passed through unmodified, with no alignment checking.
- Command changes: a requester changing its command while req is held has no effect after the grant.

Decomposition:
- Package eth_mem_pkg holds:
  - state enum {IDLE, SETUP, ACCESS}
  - owner enum {OWN_TX, OWN_RX}
  - ADDR_W and DATA_W defaults
- Natural sub-module: eth_rr_arb2, a 2-way round-robin arbiter with inputs req[1:0] and advance, and a one-hot gnt[1:0] output.
  - Its pointer is registered with the same asynchronous reset.

Test Plan:
- TX write, addr 0x0000_0040, data 0xDEAD_BEEF, pready tied to 1 -> SETUP at cycle 1, ACCESS at cycle 2 with m_pwrite_o=1; tx_done_o at cycle 3 with tx_err_o=0; rx outputs stay 0.
- RX read, addr 0x100, 3 wait states, memory returns 0x1234_5678 -> ACCESS lasts 4 cycles with the bus stable; rx_done_o one cycle later with rx_rdata_o=0x1234_5678.
- TX and RX request in the same cycle, both held for 3 transfers each -> grant order TX, RX, TX, RX, TX, RX; every request is served exactly once per done.
- TIMEOUT_CYCLES=4, pready held at 0 -> ACCESS ends after 4 cycles; done with err=1 and rdata=0; FSM returns to IDLE, and the next transfer completes normally.
- prst_i asserted during the ACCESS of a pending read -> m_psel_o and m_penable_o drop immediately (asynchronously); no done pulse; after release, TX is favoured in the first contention.
